// File: rtl/scr1_dmem_tcm_router.sv
// Data-memory router: steers core data requests to the TCM or the external port by address,
// tracks one outstanding transfer and returns the response from the port that owns it.

typedef enum logic {
  SCR1_MEM_CMD_RD = 1'b0,
  SCR1_MEM_CMD_WR = 1'b1
} type_scr1_mem_cmd_e;

typedef enum logic [1:0] {
  SCR1_MEM_WIDTH_BYTE  = 2'b00,
  SCR1_MEM_WIDTH_HWORD = 2'b01,
  SCR1_MEM_WIDTH_WORD  = 2'b10
} type_scr1_mem_width_e;

typedef enum logic [1:0] {
  SCR1_MEM_RESP_NOTRDY = 2'b00,
  SCR1_MEM_RESP_RDY_OK = 2'b01,
  SCR1_MEM_RESP_RDY_ER = 2'b10
} type_scr1_mem_resp_e;

module scr1_dmem_tcm_router #(
  parameter logic [31:0] SCR1_TCM_ADDR_MASK    = 32'hFFFF0000,
  parameter logic [31:0] SCR1_TCM_ADDR_PATTERN = 32'h00480000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // core side
  output logic                 dmem_req_ack,
  input  logic                 dmem_req,
  input  type_scr1_mem_cmd_e   dmem_cmd,
  input  type_scr1_mem_width_e dmem_width,
  input  logic [31:0]          dmem_addr,
  input  logic [31:0]          dmem_wdata,
  output logic [31:0]          dmem_rdata,
  output type_scr1_mem_resp_e  dmem_resp,
  // TCM port
  input  logic                 tcm_req_ack,
  output logic                 tcm_req,
  output type_scr1_mem_cmd_e   tcm_cmd,
  output type_scr1_mem_width_e tcm_width,
  output logic [31:0]          tcm_addr,
  output logic [31:0]          tcm_wdata,
  input  logic [31:0]          tcm_rdata,
  input  type_scr1_mem_resp_e  tcm_resp,
  // external port
  input  logic                 ext_req_ack,
  output logic                 ext_req,
  output type_scr1_mem_cmd_e   ext_cmd,
  output type_scr1_mem_width_e ext_width,
  output logic [31:0]          ext_addr,
  output logic [31:0]          ext_wdata,
  input  logic [31:0]          ext_rdata,
  input  type_scr1_mem_resp_e  ext_resp
);

  typedef enum logic {
    FSM_IDLE = 1'b0,
    FSM_WAIT = 1'b1
  } type_fsm_e;

  typedef enum logic {
    PORT_EXT = 1'b0,
    PORT_TCM = 1'b1
  } type_port_e;

  type_fsm_e           state;
  type_fsm_e           state_next;
  type_port_e          port_sel_r;
  type_port_e          port_sel_next;
  type_port_e          sel_new;
  type_scr1_mem_resp_e sel_resp;
  logic [31:0]         sel_rdata;
  logic                issue_en;
  logic                req_accept;

  assign sel_new = ((dmem_addr & SCR1_TCM_ADDR_MASK) == SCR1_TCM_ADDR_PATTERN) ? PORT_TCM : PORT_EXT;

  assign tcm_cmd   = dmem_cmd;
  assign tcm_width = dmem_width;
  assign tcm_addr  = dmem_addr;
  assign tcm_wdata = dmem_wdata;
  assign ext_cmd   = dmem_cmd;
  assign ext_width = dmem_width;
  assign ext_addr  = dmem_addr;
  assign ext_wdata = dmem_wdata;

  // Only the port owning the outstanding transfer is listened to.
  assign sel_resp  = (port_sel_r == PORT_TCM) ? tcm_resp  : ext_resp;
  assign sel_rdata = (port_sel_r == PORT_TCM) ? tcm_rdata : ext_rdata;

  // A new request may issue when idle or in the cycle the outstanding one completes.
  assign issue_en = (state == FSM_IDLE) ||
                    ((state == FSM_WAIT) && (sel_resp != SCR1_MEM_RESP_NOTRDY));

  assign tcm_req      = dmem_req & issue_en & (sel_new == PORT_TCM);
  assign ext_req      = dmem_req & issue_en & (sel_new == PORT_EXT);
  assign dmem_req_ack = issue_en & ((sel_new == PORT_TCM) ? tcm_req_ack : ext_req_ack);
  assign req_accept   = dmem_req & dmem_req_ack;

  assign dmem_resp  = (state == FSM_WAIT) ? sel_resp  : SCR1_MEM_RESP_NOTRDY;
  assign dmem_rdata = (state == FSM_WAIT) ? sel_rdata : 32'h0;

  always_comb begin
    state_next    = state;
    port_sel_next = port_sel_r;
    case (state)
      FSM_IDLE: begin
        if (req_accept) begin
          state_next    = FSM_WAIT;
          port_sel_next = sel_new;
        end
      end
      FSM_WAIT: begin
        if (sel_resp != SCR1_MEM_RESP_NOTRDY) begin
          if (req_accept) begin
            state_next    = FSM_WAIT;
            port_sel_next = sel_new;
          end else begin
            state_next    = FSM_IDLE;
          end
        end
      end
      default: begin
        state_next = FSM_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FSM_IDLE;
      port_sel_r <= PORT_EXT;
    end else begin
      state      <= state_next;
      port_sel_r <= port_sel_next;
    end
  end

endmodule

// File: tb/tb_scr1_dmem_tcm_router.sv
// Directed bench for scr1_dmem_tcm_router: address decode, handshake stalls,
// back-to-back port switching, error pass-through and reset abandonment.

module tb_scr1_dmem_tcm_router;

  logic                 clk;
  logic                 rst_n;
  logic                 dmem_req_ack;
  logic                 dmem_req;
  type_scr1_mem_cmd_e   dmem_cmd;
  type_scr1_mem_width_e dmem_width;
  logic [31:0]          dmem_addr;
  logic [31:0]          dmem_wdata;
  logic [31:0]          dmem_rdata;
  type_scr1_mem_resp_e  dmem_resp;
  logic                 tcm_req_ack;
  logic                 tcm_req;
  type_scr1_mem_cmd_e   tcm_cmd;
  type_scr1_mem_width_e tcm_width;
  logic [31:0]          tcm_addr;
  logic [31:0]          tcm_wdata;
  logic [31:0]          tcm_rdata;
  type_scr1_mem_resp_e  tcm_resp;
  logic                 ext_req_ack;
  logic                 ext_req;
  type_scr1_mem_cmd_e   ext_cmd;
  type_scr1_mem_width_e ext_width;
  logic [31:0]          ext_addr;
  logic [31:0]          ext_wdata;
  logic [31:0]          ext_rdata;
  type_scr1_mem_resp_e  ext_resp;

  int checks = 0;
  int errors = 0;

  scr1_dmem_tcm_router dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dmem_req_ack (dmem_req_ack),
    .dmem_req     (dmem_req),
    .dmem_cmd     (dmem_cmd),
    .dmem_width   (dmem_width),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .dmem_resp    (dmem_resp),
    .tcm_req_ack  (tcm_req_ack),
    .tcm_req      (tcm_req),
    .tcm_cmd      (tcm_cmd),
    .tcm_width    (tcm_width),
    .tcm_addr     (tcm_addr),
    .tcm_wdata    (tcm_wdata),
    .tcm_rdata    (tcm_rdata),
    .tcm_resp     (tcm_resp),
    .ext_req_ack  (ext_req_ack),
    .ext_req      (ext_req),
    .ext_cmd      (ext_cmd),
    .ext_width    (ext_width),
    .ext_addr     (ext_addr),
    .ext_wdata    (ext_wdata),
    .ext_rdata    (ext_rdata),
    .ext_resp     (ext_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then changed and checked mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] bnd_addr [4];
  logic        bnd_tcm  [4];

  initial begin
    rst_n       = 1'b0;
    dmem_req    = 1'b0;
    dmem_cmd    = SCR1_MEM_CMD_RD;
    dmem_width  = SCR1_MEM_WIDTH_WORD;
    dmem_addr   = 32'h0;
    dmem_wdata  = 32'h0;
    tcm_req_ack = 1'b0;
    tcm_rdata   = 32'h0;
    tcm_resp    = SCR1_MEM_RESP_NOTRDY;
    ext_req_ack = 1'b0;
    ext_rdata   = 32'h0;
    ext_resp    = SCR1_MEM_RESP_NOTRDY;
    bnd_addr[0] = 32'h0047FFFC; bnd_tcm[0] = 1'b0;
    bnd_addr[1] = 32'h00480000; bnd_tcm[1] = 1'b1;
    bnd_addr[2] = 32'h0048FFFC; bnd_tcm[2] = 1'b1;
    bnd_addr[3] = 32'h00490000; bnd_tcm[3] = 1'b0;

    // reset state
    tick();
    #1;
    check("rst_resp", 32'(dmem_resp), 32'(SCR1_MEM_RESP_NOTRDY));
    check("rst_rdata", dmem_rdata, 32'h0);
    check("rst_ack", 32'(dmem_req_ack), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // TCM read, acked immediately
    dmem_req    = 1'b1;
    dmem_addr   = 32'h00480010;
    tcm_req_ack = 1'b1;
    #1;
    check("rd_tcm_req", 32'(tcm_req), 32'h1);
    check("rd_ext_req", 32'(ext_req), 32'h0);
    check("rd_ack", 32'(dmem_req_ack), 32'h1);
    check("rd_bcast_addr", ext_addr, 32'h00480010);
    check("rd_bcast_width", 32'(tcm_width), 32'(SCR1_MEM_WIDTH_WORD));
    tick();
    dmem_req    = 1'b0;
    tcm_req_ack = 1'b0;
    tcm_resp    = SCR1_MEM_RESP_RDY_OK;
    tcm_rdata   = 32'hDEADBEEF;
    #1;
    check("rd_resp", 32'(dmem_resp), 32'(SCR1_MEM_RESP_RDY_OK));
    check("rd_rdata", dmem_rdata, 32'hDEADBEEF);
    tick();
    #1;
    check("rd_idle_resp", 32'(dmem_resp), 32'(SCR1_MEM_RESP_NOTRDY));
    check("rd_idle_rdata", dmem_rdata, 32'h0);
    tcm_resp  = SCR1_MEM_RESP_NOTRDY;
    tcm_rdata = 32'h0;

    // EXT write with two stalled cycles
    dmem_req   = 1'b1;
    dmem_cmd   = SCR1_MEM_CMD_WR;
    dmem_addr  = 32'h00010000;
    dmem_wdata = 32'h12345678;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("wr_stall_ext_req", 32'(ext_req), 32'h1);
      check("wr_stall_tcm_req", 32'(tcm_req), 32'h0);
      check("wr_stall_ack", 32'(dmem_req_ack), 32'h0);
      tick();
    end
    ext_req_ack = 1'b1;
    #1;
    check("wr_ext_req", 32'(ext_req), 32'h1);
    check("wr_ack", 32'(dmem_req_ack), 32'h1);
    check("wr_wdata", ext_wdata, 32'h12345678);
    check("wr_cmd", 32'(ext_cmd), 32'(SCR1_MEM_CMD_WR));
    tick();
    // outstanding, not ready: a new TCM request must be held off
    ext_req_ack = 1'b0;
    dmem_cmd    = SCR1_MEM_CMD_RD;
    dmem_addr   = 32'h00480004;
    tcm_req_ack = 1'b1;
    #1;
    check("wr_wait_resp", 32'(dmem_resp), 32'(SCR1_MEM_RESP_NOTRDY));
    check("wr_wait_tcm_req", 32'(tcm_req), 32'h0);
    check("wr_wait_ack", 32'(dmem_req_ack), 32'h0);
    tick();
    dmem_req    = 1'b0;
    tcm_req_ack = 1'b0;
    ext_resp    = SCR1_MEM_RESP_RDY_OK;
    #1;
    check("wr_done_resp", 32'(dmem_resp), 32'(SCR1_MEM_RESP_RDY_OK));
    tick();
    ext_resp = SCR1_MEM_RESP_NOTRDY;

    // back-to-back: TCM completes while EXT read is accepted
    dmem_req    = 1'b1;
    dmem_addr   = 32'h00480000;
    tcm_req_ack = 1'b1;
    #1;
    check("b2b_tcm_req", 32'(tcm_req), 32'h1);
    tick();
    tcm_req_ack = 1'b0;
    tcm_resp    = SCR1_MEM_RESP_RDY_OK;
    tcm_rdata   = 32'h11112222;
    dmem_addr   = 32'h00001000;
    ext_req_ack = 1'b1;
    #1;
    check("b2b_resp", 32'(dmem_resp), 32'(SCR1_MEM_RESP_RDY_OK));
    check("b2b_rdata", dmem_rdata, 32'h11112222);
    check("b2b_ext_req", 32'(ext_req), 32'h1);
    check("b2b_ack", 32'(dmem_req_ack), 32'h1);
    tick();
    dmem_req    = 1'b0;
    ext_req_ack = 1'b0;
    #1;
    check("b2b_ext_wait_resp", 32'(dmem_resp), 32'(SCR1_MEM_RESP_NOTRDY));
    tick();
    // error on EXT wins over a stray TCM response
    ext_resp  = SCR1_MEM_RESP_RDY_ER;
    ext_rdata = 32'hBAD0BAD0;
    #1;
    check("err_resp", 32'(dmem_resp), 32'(SCR1_MEM_RESP_RDY_ER));
    check("err_rdata", dmem_rdata, 32'hBAD0BAD0);
    tick();
    #1;
    check("err_idle_resp", 32'(dmem_resp), 32'(SCR1_MEM_RESP_NOTRDY));
    ext_resp  = SCR1_MEM_RESP_NOTRDY;
    ext_rdata = 32'h0;
    tcm_resp  = SCR1_MEM_RESP_NOTRDY;
    tcm_rdata = 32'h0;

    // reset while a TCM transfer is outstanding
    dmem_req    = 1'b1;
    dmem_addr   = 32'h00480020;
    tcm_req_ack = 1'b1;
    tick();
    dmem_req    = 1'b0;
    tcm_req_ack = 1'b0;
    rst_n       = 1'b0;
    #1;
    check("rst_wait_resp", 32'(dmem_resp), 32'(SCR1_MEM_RESP_NOTRDY));
    tick();
    rst_n     = 1'b1;
    tcm_resp  = SCR1_MEM_RESP_RDY_OK;
    tcm_rdata = 32'hCAFEF00D;
    #1;
    check("rst_late_resp", 32'(dmem_resp), 32'(SCR1_MEM_RESP_NOTRDY));
    check("rst_late_rdata", dmem_rdata, 32'h0);
    tick();
    #1;
    check("rst_late_resp2", 32'(dmem_resp), 32'(SCR1_MEM_RESP_NOTRDY));
    tcm_resp  = SCR1_MEM_RESP_NOTRDY;
    tcm_rdata = 32'h0;

    // decode boundaries (no acks, so the FSM stays idle)
    dmem_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dmem_addr = bnd_addr[i];
      #1;
      check($sformatf("bnd_tcm_req_%0d", i), 32'(tcm_req), 32'(bnd_tcm[i]));
      check($sformatf("bnd_ext_req_%0d", i), 32'(ext_req), 32'(!bnd_tcm[i]));
      tick();
    end
    dmem_req = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scr1_dmem_tcm_router.md
SCR1_DMEM_TCM_ROUTER -- requirements
Module: scr1_dmem_tcm_router

Interface
REQ-001 SHALL provide parameter SCR1_TCM_ADDR_MASK, default 32'hFFFF0000, address bits compared for TCM decode.
REQ-002 SHALL provide parameter SCR1_TCM_ADDR_PATTERN, default 32'h00480000, value that masked address must equal for TCM hit.
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk input 1 system clock; rst_n input 1 async active-low reset.
REQ-004 dmem_req_ack  output  1  core request accepted this cycle.
REQ-005 dmem_req  input  1  core data request valid.
REQ-006 dmem_cmd  input  type_scr1_mem_cmd_e  read/write.
REQ-007 dmem_width  input  type_scr1_mem_width_e  byte/hword/word.
REQ-008 dmem_addr  input  32  byte address.
REQ-009 dmem_wdata  input  32  write data.
REQ-010 dmem_rdata  output  32  read data to core.
REQ-011 dmem_resp  output  type_scr1_mem_resp_e  response to core.
REQ-012 Per port X in {tcm, ext}: X_req_ack input 1; X_req output 1; X_cmd, X_width output enum; X_addr, X_wdata output 32; X_rdata input 32; X_resp input type_scr1_mem_resp_e.

Function
REQ-013 SHALL decode sel_new = TCM when (dmem_addr & SCR1_TCM_ADDR_MASK) == SCR1_TCM_ADDR_PATTERN, else EXT.
REQ-014 SHALL broadcast dmem_cmd, dmem_width, dmem_addr, dmem_wdata unchanged to both ports every cycle.
REQ-015 SHALL implement FSM states IDLE (no outstanding transfer) and WAIT (one transfer outstanding on port_sel_r).
REQ-016 SHALL define issue_en = (state==IDLE) or (state==WAIT and selected-port resp != NOTRDY).
REQ-017 SHALL drive tcm_req = dmem_req & issue_en & (sel_new==TCM); ext_req = dmem_req & issue_en & (sel_new==EXT); never both high.
REQ-018 SHALL drive dmem_req_ack = issue_en & (sel_new==TCM ? tcm_req_ack : ext_req_ack); 0 when issue_en low.
REQ-019 On dmem_req & dmem_req_ack SHALL go to WAIT and register port_sel_r <= sel_new at the clock edge.
REQ-020 In WAIT SHALL drive dmem_resp and dmem_rdata combinationally from port_sel_r's port (zero latency added); in IDLE dmem_resp = NOTRDY, dmem_rdata = 0.
REQ-021 In WAIT with selected resp RDY_OK or RDY_ER and no new accepted request SHALL go to IDLE; with a new accepted request SHALL stay WAIT with updated port_sel_r (back-to-back, switching ports allowed).
REQ-022 In WAIT with selected resp NOTRDY SHALL stay WAIT, keep port_sel_r, assert no port req.
REQ-023 SHALL ignore X_resp of the non-selected port and any X_resp while IDLE.
REQ-024 SHALL pass RDY_ER through unchanged; an errored transfer completes exactly like RDY_OK.
REQ-025 dmem_req held with X_req_ack low SHALL keep X_req high each cycle until acked; FSM unchanged.

Reset
REQ-026 rst_n low SHALL asynchronously force state=IDLE, port_sel_r=EXT; outputs then dmem_req_ack=0 (unless dmem_req hits an acking port), dmem_resp=NOTRDY, dmem_rdata=0.
REQ-027 Reset mid-WAIT SHALL abandon the outstanding transfer; a late port resp after reset release SHALL be ignored (IDLE).
REQ-028 No other registered state SHALL exist.

Verification
REQ-029 Read 0x00480010, tcm acks, tcm_resp RDY_OK next cycle with rdata 0xDEADBEEF -> tcm_req=1, ext_req=0; dmem_resp RDY_OK, dmem_rdata 0xDEADBEEF; then IDLE.
REQ-030 Write 0x00010000 word 0x12345678, ext_req_ack low 2 cycles -> ext_req high 3 cycles, dmem_req_ack only in 3rd; ext_wdata 0x12345678.
REQ-031 Back-to-back: TCM read completes in the same cycle a read to 0x00001000 is accepted -> port_sel_r becomes EXT, FSM stays WAIT, ext response routed next.
REQ-032 ext_resp RDY_ER while WAIT on EXT, tcm_resp RDY_OK same cycle -> dmem_resp RDY_ER, tcm_resp ignored.
REQ-033 Assert rst_n low in WAIT, release, then drive tcm_resp RDY_OK -> dmem_resp stays NOTRDY, state IDLE.
REQ-034 Masked-hit boundary: 0x0047FFFC -> EXT, 0x00480000 -> TCM, 0x0048FFFC -> TCM, 0x00490000 -> EXT.
